rr_wire_arbiter: RTL and testbench

- Round-robin scheduler that shares one single-bit output wire among N requesters.
- Grants exactly one requester at a time and routes that requester's data bit onto the shared wire.
- Bounds ownership with a hold counter so no requester starves.
- Sits between the requester bits and the shared one-bit channel; the channel itself is a pure pass-through.

---
 rtl/rr_wire_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_wire_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_wire_arbiter.sv
// rr_wire_arbiter
//   Round-robin owner selection for one shared single-bit wire. Exactly one
//   requester owns the wire at a time. Its data bit is routed onto `out`.
//   A hold counter bounds how long an owner keeps the wire while others wait.
//
// Ports
//   clk        sole clock, rising edge
//   aresetn    asynchronous active-low reset
//   req[N]     level requests, held high while the wire is wanted
//   din[N]     per-requester data bits
//   gnt[N]     registered one-hot grant, zero when idle
//   gnt_id     registered binary owner index, keeps last value when idle
//   out        din[gnt_id] while a grant is active, else 0 (combinational)
//   out_valid  |gnt
module rr_wire_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   din,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           out,
    output logic           out_valid
);

    // state  | meaning
    // S_IDLE | no owner; the wire is driven low
    // S_BUSY | gnt_id owns the wire; hold_cnt counts its tenure
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] gnt_id_n;
    logic [IDW-1:0] own_inc;
    logic [HW-1:0]  hold_cnt, hold_cnt_n;
    logic [N-1:0]   gnt_n;
    logic [N-1:0]   others;

    // First requester at or after p in circular order. Distance is computed
    // arithmetically so the index scan stays a fixed loop.
    function automatic logic [IDW-1:0] scan_from(input logic [N-1:0]   r,
                                                 input logic [IDW-1:0] p);
        logic [IDW-1:0] sel;
        int             best_d;
        int             d;
        sel    = '0;
        best_d = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = i - int'(p);
                if (d < 0) d = d + N;
                if (d < best_d) begin
                    best_d = d;
                    sel    = IDW'(i);
                end
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        gnt_id_n   = gnt_id;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        own_inc    = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        // gnt is one-hot on the owner, so this is every waiting requester
        others     = req & ~gnt;

        case (state)
            S_IDLE: begin
                if (|req) begin
                    gnt_id_n   = scan_from(req, ptr);
                    gnt_n      = N'(1) << gnt_id_n;
                    hold_cnt_n = HW'(1);
                    state_n    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!req[gnt_id]) begin
                    ptr_n = own_inc;
                    if (|others) begin
                        // hand over on the same edge, no idle bubble
                        gnt_id_n   = scan_from(req, own_inc);
                        gnt_n      = N'(1) << gnt_id_n;
                        hold_cnt_n = HW'(1);
                    end else begin
                        gnt_n   = '0;
                        state_n = S_IDLE;
                    end
                end else if ((hold_cnt == HW'(MAX_HOLD)) && (|others)) begin
                    ptr_n      = own_inc;
                    gnt_id_n   = scan_from(others, own_inc);
                    gnt_n      = N'(1) << gnt_id_n;
                    hold_cnt_n = HW'(1);
                end else if (hold_cnt != HW'(MAX_HOLD)) begin
                    // saturate while alone so preemption fires as soon as
                    // a competitor shows up
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign out_valid = |gnt;
    assign out       = out_valid & din[gnt_id];

endmodule

// File: tb/tb_rr_wire_arbiter.sv
module tb_rr_wire_arbiter;

    logic       clk;
    logic       aresetn;
    logic [3:0] req_a, din_a, gnt_a;
    logic [1:0] id_a;
    logic       out_a, ov_a;
    logic [3:0] req_b, din_b, gnt_b;
    logic [1:0] id_b;
    logic       out_b, ov_b;

    int total;
    int bad;

    rr_wire_arbiter #(.N(4), .MAX_HOLD(8)) dut_a (
        .clk(clk), .aresetn(aresetn), .req(req_a), .din(din_a),
        .gnt(gnt_a), .gnt_id(id_a), .out(out_a), .out_valid(ov_a)
    );

    rr_wire_arbiter #(.N(4), .MAX_HOLD(1)) dut_b (
        .clk(clk), .aresetn(aresetn), .req(req_b), .din(din_b),
        .gnt(gnt_b), .gnt_id(id_b), .out(out_b), .out_valid(ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the wire, how long it has owned it, and where
    // the next circular search starts.
    typedef struct {
        bit busy;
        int owner;
        int ptr;
        int ten;
    } model_t;

    model_t ma, mb;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        int         id;
    } vec_t;

    vec_t tbl[12];

    function automatic int bit_of(input logic [3:0] v, input int i);
        return int'((v >> i) & 4'd1);
    endfunction

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (bit_of(r, (p + k) % 4) == 1) return (p + k) % 4;
        end
        return 0;
    endfunction

    function automatic model_t model_edge(input model_t m, input logic [3:0] r, input int mh);
        model_t n;
        int     waiting;
        n = m;
        if (!m.busy) begin
            if (r != 4'd0) begin
                n.busy  = 1'b1;
                n.owner = first_from(r, m.ptr);
                n.ten   = 1;
            end
        end else begin
            waiting = int'(r) & ~(1 << m.owner);
            if (bit_of(r, m.owner) == 0) begin
                n.ptr = (m.owner + 1) % 4;
                if (r != 4'd0) begin
                    n.owner = first_from(r, n.ptr);
                    n.ten   = 1;
                end else begin
                    n.busy = 1'b0;
                end
            end else if (m.ten >= mh && waiting != 0) begin
                n.ptr   = (m.owner + 1) % 4;
                n.owner = first_from(4'(waiting), n.ptr);
                n.ten   = 1;
            end else begin
                n.ten = m.ten + 1;
            end
        end
        return n;
    endfunction

    function automatic int exp_gnt(input model_t m);
        return m.busy ? (1 << m.owner) : 0;
    endfunction

    function automatic int exp_out(input model_t m, input logic [3:0] d);
        return m.busy ? bit_of(d, m.owner) : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gnt_a", int'(gnt_a), exp_gnt(ma));
        chk("id_a", int'(id_a), ma.owner);
        chk("ov_a", int'(ov_a), int'(ma.busy));
        chk("out_a", int'(out_a), exp_out(ma, din_a));
        chk("gnt_b", int'(gnt_b), exp_gnt(mb));
        chk("id_b", int'(id_b), mb.owner);
        chk("ov_b", int'(ov_b), int'(mb.busy));
        chk("out_b", int'(out_b), exp_out(mb, din_b));
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic step(input logic [3:0] ra, input logic [3:0] da,
                        input logic [3:0] rb, input logic [3:0] db);
        req_a = ra; din_a = da; req_b = rb; din_b = db;
        #1;
        chk("out_comb_a", int'(out_a), exp_out(ma, din_a));
        chk("out_comb_b", int'(out_b), exp_out(mb, din_b));
        @(posedge clk);
        ma = model_edge(ma, ra, 8);
        mb = model_edge(mb, rb, 1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_gnt_a", int'(gnt_a), 0);
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_ov_a", int'(ov_a), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        chk("rst_out_b", int'(out_b), 0);
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        @(posedge clk);
        #1;
        chk("rst_id_a", int'(id_a), 0);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [3:0] ra, rb, prev;
        int         changes;

        total = 0; bad = 0;
        aresetn = 1'b0;
        req_a = '0; din_a = '0; req_b = '0; din_b = '0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        // early release, hand-over, wrap-around search, idle return
        tbl[0]  = '{4'b0011, 4'b0001, 4'b0001, 0};
        tbl[1]  = '{4'b0011, 4'b0010, 4'b0001, 0};
        tbl[2]  = '{4'b0011, 4'b0011, 4'b0001, 0};
        tbl[3]  = '{4'b0010, 4'b0010, 4'b0010, 1};
        tbl[4]  = '{4'b0010, 4'b0000, 4'b0010, 1};
        tbl[5]  = '{4'b0000, 4'b1111, 4'b0000, 1};
        tbl[6]  = '{4'b1000, 4'b1000, 4'b1000, 3};
        tbl[7]  = '{4'b0101, 4'b0001, 4'b0001, 0};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 2};
        tbl[9]  = '{4'b0000, 4'b0100, 4'b0000, 2};
        tbl[10] = '{4'b0011, 4'b0001, 4'b0001, 0};
        tbl[11] = '{4'b0000, 4'b0001, 4'b0000, 0};

        @(posedge clk);
        #1;
        chk("init_gnt_a", int'(gnt_a), 0);
        chk("init_ov_a", int'(ov_a), 0);
        chk("init_out_a", int'(out_a), 0);
        aresetn = 1'b1;

        for (int i = 0; i < 5; i++) step(4'b0000, 4'(i), 4'b0000, 4'b0000);

        // single requester keeps the wire indefinitely
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 4'($urandom_range(0, 15)), 4'b0000, 4'b0000);
            chk("single_gnt", int'(gnt_a), 4);
            chk("single_id", int'(id_a), 2);
            chk("single_out", int'(out_a), bit_of(din_a, 2));
        end

        // reset dropped mid-grant clears outputs before the next edge
        chk("pre_rst_ov", int'(ov_a), 1);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].din, 4'b0000, 4'b0000);
            chk("tbl_gnt", int'(gnt_a), int'(tbl[i].gnt));
            chk("tbl_id", int'(id_a), tbl[i].id);
            chk("tbl_ov", int'(ov_a), int'(tbl[i].gnt != 4'd0));
            chk("tbl_out", int'(out_a), bit_of(tbl[i].din, tbl[i].id) & int'(tbl[i].gnt != 4'd0));
        end

        // full contention on the 8-cycle build, alternation on the 1-cycle build
        do_reset();
        changes = 0;
        prev    = '0;
        for (int t = 0; t < 40; t++) begin
            step(4'b1111, 4'($urandom_range(0, 15)), 4'b1010, 4'($urandom_range(0, 15)));
            chk("rot_gnt", int'(gnt_a), 1 << ((t / 8) % 4));
            chk("alt_gnt", int'(gnt_b), (t % 2 == 0) ? 2 : 8);
            chk("alt_out", int'(out_b), bit_of(din_b, (t % 2 == 0) ? 1 : 3));
            if (t > 0 && gnt_a != prev) changes++;
            prev = gnt_a;
        end
        chk("rot_changes", changes, 4);

        // sticky random requests against the model
        do_reset();
        ra = '0; rb = '0;
        for (int i = 0; i < 3000; i++) begin
            ra = ra ^ 4'($urandom & $urandom & $urandom);
            rb = rb ^ 4'($urandom & $urandom);
            step(ra, 4'($urandom_range(0, 15)), rb, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
